// File: rtl/keypad_matrix_scanner.sv
// Scans a 4x3 membrane keypad, debounces whole-matrix frames and emits a one-hot digit 0-9.
// Optional auto-repeat strobes are built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_FRAMES  = 50
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       key_held,
    output logic       key_strobe
);

    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [3:0] CODE_NONE  = 4'd10;
    localparam logic [3:0] CODE_MULTI = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_LOCKOUT
    } state_t;

    logic [2:0]        r_col_meta;
    logic [2:0]        r_col_sync;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_row;
    logic [9:0]        r_hits;
    logic [3:0]        r_prev_code;
    logic [CNT_W-1:0]  r_stable_cnt;
    logic              r_frame_done;
    logic              r_commit;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [9:0]        r_keypad;
    logic [9:0]        w_keypad_nxt;
    logic              r_strobe;
    logic              w_strobe_nxt;
    logic              w_slot_end;
    logic              w_frame_end;
    logic [9:0]        w_row_hits;
    logic [9:0]        w_frame_hits;
    logic [3:0]        w_frame_code;
    logic [9:0]        w_code_onehot;

    // Frame code: digit 0-9, CODE_NONE, or CODE_MULTI for two or more closures.
    function automatic logic [3:0] encode_frame(input logic [9:0] hits);
        logic [3:0]  code;
        int unsigned n;
        code = CODE_NONE;
        n    = 0;
        for (int unsigned k = 0; k < 10; k++) begin
            if (hits[k]) begin
                n++;
                code = 4'(k);
            end
        end
        if (n > 1) begin
            code = CODE_MULTI;
        end
        return code;
    endfunction

    assign w_slot_end    = (r_slot == SLOT_W'(SCAN_DIV - 1));
    assign w_frame_end   = w_slot_end && (r_row == 2'd3);
    assign w_frame_hits  = r_hits | w_row_hits;
    assign w_frame_code  = encode_frame(w_frame_hits);
    assign w_code_onehot = 10'b1 << r_prev_code;

    // Map the active row's closed columns onto digit bits; (3,0) and (3,2) are unmapped.
    always_comb begin
        w_row_hits = '0;
        case (r_row)
            2'd0:    w_row_hits = {6'b0, ~r_col_sync, 1'b0};
            2'd1:    w_row_hits = {3'b0, ~r_col_sync, 4'b0};
            2'd2:    w_row_hits = {~r_col_sync, 7'b0};
            default: w_row_hits = {9'b0, ~r_col_sync[1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta   <= '1;
            r_col_sync   <= '1;
            r_slot       <= '0;
            r_row        <= '0;
            r_hits       <= '0;
            r_prev_code  <= CODE_NONE;
            r_stable_cnt <= '0;
            r_frame_done <= 1'b0;
            r_commit     <= 1'b0;
        end else begin
            r_col_meta   <= col_n;
            r_col_sync   <= r_col_meta;
            r_frame_done <= 1'b0;
            r_commit     <= 1'b0;
            if (w_slot_end) begin
                r_slot <= '0;
                r_row  <= r_row + 2'd1;
                if (w_frame_end) begin
                    r_hits       <= '0;
                    r_frame_done <= 1'b1;
                    // Commit fires only on the frame that brings the run up to the threshold.
                    if (w_frame_code == r_prev_code) begin
                        if (r_stable_cnt < CNT_W'(DEBOUNCE_SCANS)) begin
                            r_stable_cnt <= r_stable_cnt + 1'b1;
                            r_commit     <= (r_stable_cnt == CNT_W'(DEBOUNCE_SCANS - 1));
                        end
                    end else begin
                        r_stable_cnt <= CNT_W'(1);
                        r_prev_code  <= w_frame_code;
                    end
                end else begin
                    r_hits <= w_frame_hits;
                end
            end else begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_keypad_nxt = r_keypad;
        w_strobe_nxt = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_nxt    = r_rep;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_commit) begin
                    if (r_prev_code == CODE_MULTI) begin
                        w_state_nxt = S_LOCKOUT;
                    end else if (r_prev_code != CODE_NONE) begin
                        w_state_nxt  = S_HELD;
                        w_keypad_nxt = w_code_onehot;
                        w_strobe_nxt = 1'b1;
                    end
                end
            end
            S_HELD: begin
                // NONE and MULTI give a zero one-hot, so any differing commit releases.
                if (r_commit && (w_code_onehot != r_keypad)) begin
                    w_keypad_nxt = '0;
                    w_state_nxt  = (r_prev_code == CODE_MULTI) ? S_LOCKOUT : S_IDLE;
`ifdef KEYPAD_AUTOREPEAT_EN
                    w_rep_nxt    = '0;
`endif
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (r_frame_done) begin
                    if (r_rep == REP_W'(REPEAT_FRAMES - 1)) begin
                        w_rep_nxt    = '0;
                        w_strobe_nxt = 1'b1;
                    end else begin
                        w_rep_nxt = r_rep + 1'b1;
                    end
                end
`endif
            end
            S_LOCKOUT: begin
                w_keypad_nxt = '0;
                if (r_commit && (r_prev_code == CODE_NONE)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_keypad_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_keypad <= '0;
            r_strobe <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_keypad <= w_keypad_nxt;
            r_strobe <= w_strobe_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep    <= w_rep_nxt;
`endif
        end
    end

    assign row_n      = ~(4'b0001 << r_row);
    assign keypad     = r_keypad;
    assign key_held   = |r_keypad;
    assign key_strobe = r_strobe;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: frame-level reference model feeds expected
// keypad changes and strobes into queues; a negedge monitor pops and compares them.
module tb_keypad_matrix_scanner;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;
    localparam int RR    = 2;
    localparam int NONE  = -1;
    localparam int MULTI = -2;

    logic       clk;
    logic       rst;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       key_held;
    logic       key_strobe;

    logic [11:0] pressed;
    int          cyc;
    bit          mon_en;
    int          n_checks;
    int          n_pass;

    typedef struct {
        int         cyc;
        logic [9:0] val;
    } ev_t;

    ev_t        chg_q[$];
    ev_t        stb_q[$];
    logic [9:0] last_kp;
    logic [9:0] exp_kp;

    int hist[$];
    int m_held;
    bit m_locked;
    int m_fc;

    keypad_matrix_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DB)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_FRAMES(RR)
`endif
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .col_n(col_n),
        .row_n(row_n),
        .keypad(keypad),
        .key_held(key_held),
        .key_strobe(key_strobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Passive membrane matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++) begin
            if (row_n[r] == 1'b0) begin
                for (int c = 0; c < 3; c++) begin
                    if (pressed[3*r+c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [11:0] kbit(input int d);
        logic [11:0] b;
        b = '0;
        if (d == 0) b[10] = 1'b1;
        else b[d-1] = 1'b1;
        return b;
    endfunction

    function automatic logic [9:0] onehot(input int d);
        logic [9:0] v;
        v = 10'd1 << d;
        return v;
    endfunction

    // Frame-level reference: derive the frame code from what each row saw, commit when a run
    // of identical codes since reset first reaches DB, then apply the press/release rules.
    task automatic model_frame(input logic [11:0] keys, input int br, input logic [11:0] alt);
        int n_cl;
        int code;
        int len;
        int t;
        bit commit;
        bit closed;
        n_cl = 0;
        code = NONE;
        for (int p = 0; p < 12; p++) begin
            if (p == 9 || p == 11) continue;
            closed = ((p / 3) == br) ? alt[p] : keys[p];
            if (closed) begin
                n_cl++;
                code = (p == 10) ? 0 : p + 1;
            end
        end
        if (n_cl > 1) code = MULTI;
        hist.push_back(code);
        len    = hist.size();
        commit = 1'b0;
        if (len >= DB) begin
            commit = 1'b1;
            for (int i = 1; i < DB; i++) if (hist[len-1-i] != code) commit = 1'b0;
            if (len > DB && hist[len-1-DB] == code) commit = 1'b0;
        end
        t = cyc + 2;
        if (commit) begin
            if (m_locked) begin
                if (code == NONE) m_locked = 1'b0;
            end else if (m_held >= 0) begin
                if (code != m_held) begin
                    m_held = -1;
                    chg_q.push_back('{cyc: t, val: 10'd0});
                    if (code == MULTI) m_locked = 1'b1;
                end
            end else if (code == MULTI) begin
                m_locked = 1'b1;
            end else if (code >= 0) begin
                m_held = code;
                m_fc   = len - 1;
                chg_q.push_back('{cyc: t, val: onehot(code)});
                stb_q.push_back('{cyc: t, val: onehot(code)});
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_held >= 0 && (len - 1 - m_fc) > 0 && ((len - 1 - m_fc) % RR) == 0)
            stb_q.push_back('{cyc: t, val: onehot(m_held)});
`endif
    endtask

    task automatic model_reset();
        if (m_held >= 0) chg_q.push_back('{cyc: 0, val: 10'd0});
        hist.delete();
        m_held   = -1;
        m_locked = 1'b0;
        m_fc     = 0;
    endtask

    // Drive one frame; row slot br (if 0..3) sees alt instead of keys.
    task automatic do_frame(input logic [11:0] keys, input int br, input logic [11:0] alt);
        for (int s = 0; s < FRAME; s++) begin
            pressed = ((s / SD) == br) ? alt : keys;
            if (s == FRAME - 1) model_frame(keys, br, alt);
            @(negedge clk);
        end
    endtask

    task automatic hold(input logic [11:0] keys, input int n);
        for (int i = 0; i < n; i++) do_frame(keys, -1, 12'd0);
    endtask

    task automatic do_reset_mid(input logic [11:0] keys, input int off);
        for (int s = 0; s < off; s++) begin
            pressed = keys;
            @(negedge clk);
        end
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_row;
        ev_t        e;
        if (mon_en) begin
            exp_row = ~(4'b0001 << ((cyc / SD) % 4));
            chk("row_n", 32'(row_n), 32'(exp_row));
            if (key_strobe === 1'b1) begin
                chk("strobe_expected", 32'(stb_q.size() != 0), 32'd1);
                if (stb_q.size() != 0) begin
                    e = stb_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_keypad", 32'(keypad), 32'(e.val));
                end
            end
            if (keypad !== last_kp) begin
                chk("change_expected", 32'(chg_q.size() != 0), 32'd1);
                if (chg_q.size() != 0) begin
                    e = chg_q.pop_front();
                    chk("change_cycle", cyc, e.cyc);
                    chk("keypad_value", 32'(keypad), 32'(e.val));
                    exp_kp = e.val;
                end
                last_kp = keypad;
            end
            chk("key_held", 32'(key_held), 32'(exp_kp != 10'd0));
        end
    end

    initial begin
        logic [11:0] keys;
        logic [11:0] alt;
        int          kind;
        int          d1;
        int          d2;
        int          len;
        int          br;
        rst      = 1'b1;
        pressed  = '0;
        mon_en   = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        last_kp  = '0;
        exp_kp   = '0;
        m_held   = -1;
        m_locked = 1'b0;
        m_fc     = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_row_n", 32'(row_n), 32'h0000_000E);
        chk("reset_keypad", 32'(keypad), 32'd0);
        chk("reset_key_held", 32'(key_held), 32'd0);
        chk("reset_key_strobe", 32'(key_strobe), 32'd0);
        mon_en = 1'b1;

        hold(12'd0, 3);
        hold(kbit(5), 5);
        hold(12'd0, 5);
        hold(kbit(0), 2);
        do_frame(kbit(0), 3, 12'd0);
        hold(kbit(0), 5);
        hold(12'd0, 4);
        hold(kbit(1) | kbit(9), 4);
        hold(kbit(9), 4);
        hold(12'd0, 4);
        hold(kbit(9), 5);
        hold(12'd0, 4);
        hold(kbit(7), 5);
        do_reset_mid(kbit(7), 6);
        hold(kbit(7), 5);
        hold(12'd0, 4);
`ifdef KEYPAD_AUTOREPEAT_EN
        hold(kbit(3), 9);
        hold(12'd0, 4);
`endif

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 4);
            d1   = $urandom_range(0, 9);
            d2   = (d1 + $urandom_range(1, 9)) % 10;
            case (kind)
                0:       keys = 12'd0;
                1:       keys = kbit(d1);
                2:       keys = kbit(d1) | kbit(d2);
                3:       keys = kbit(d1) | 12'h200;
                default: keys = ($urandom_range(0, 1) == 0) ? 12'h800 : 12'h200;
            endcase
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                br  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
                alt = keys ^ (12'd1 << $urandom_range(0, 11));
                do_frame(keys, br, alt);
            end
            if ($urandom_range(0, 9) == 0) do_reset_mid(keys, $urandom_range(2, 13));
        end

        hold(12'd0, 5);
        chk("strobe_queue_drained", stb_q.size(), 32'd0);
        chk("change_queue_drained", chg_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
